// File: rtl/prog_feeder_pkg.sv
// Shared definitions for the program feeder: state encoding, sizing defaults,
// the HALT opcode and the invalid-request counter saturation value.
package prog_feeder_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DEPTH_DEF  = 64;
  localparam int unsigned WORD_W     = 16;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned CNT_W      = 8;

  localparam logic [BYTE_W-1:0] HALT_OPCODE = 8'hFF;
  localparam logic [CNT_W-1:0]  CNT_MAX     = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_OPCODE   = 3'd1,
    ST_IMM      = 3'd2,
    ST_WAIT_REQ = 3'd3,
    ST_ADDR     = 3'd4
  } state_e;

endpackage

// File: rtl/prog_feeder_mem.sv
// Program store: DEPTH x 16 register array, synchronous write, asynchronous read.
// No reset: contents survive rst.
// Ports: clk; we_i/waddr_i/wdata_i write port; raddr_i/rdata_o read port.
module prog_mem
  import prog_feeder_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_feeder.sv
// Feeds a small CPU its program one byte per cycle (opcode, then immediate),
// waiting for a rising edge on the CPU request line between instructions.
// Ports: clk, rst (async, active-high); run_i host start/stop;
//   wr_en_i/wr_addr_i/wr_data_i host program write (accepted in IDLE only);
//   cpu_req_i/cpu_invalid_i/cpu_pc_i CPU request side;
//   cpu_bus_o/cpu_bus_valid_o instruction bytes; halted_o sticky HALT flag;
//   wr_err_o rejected-write pulse; invalid_cnt_o saturating invalid count.
module prog_feeder
  import prog_feeder_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              cpu_req_i,
  input  logic              cpu_invalid_i,
  input  logic [ADDR_W-1:0] cpu_pc_i,
  output logic [BYTE_W-1:0] cpu_bus_o,
  output logic              cpu_bus_valid_o,
  output logic              halted_o,
  output logic              wr_err_o,
  output logic [CNT_W-1:0]  invalid_cnt_o
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                req_q;
  logic                run_q;
  logic [BYTE_W-1:0]   bus_q, bus_d;
  logic                valid_q, valid_d;
  logic                halted_q, halted_d;
  logic                wr_err_q, wr_err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                req_edge;
  logic                mem_we;
  logic [ADDR_W-1:0]   rd_addr;
  logic [WORD_W-1:0]   rd_data;
  logic [WORD_W-1:0]   fwd_data;

  assign req_edge = cpu_req_i & ~req_q;
  assign mem_we   = wr_en_i && (state_q == ST_IDLE);

  // Read address is the address the next registered byte comes from:
  // 0 when starting from IDLE, the CPU PC when leaving ADDR, else the held address.
  always_comb begin
    rd_addr = addr_q;
    if (state_q == ST_IDLE)      rd_addr = '0;
    else if (state_q == ST_ADDR) rd_addr = cpu_pc_i;
  end

  // A write landing on the same edge as the start must be seen by the first opcode.
  assign fwd_data = (mem_we && (wr_addr_i == rd_addr)) ? wr_data_i : rd_data;

  prog_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_addr_i),
    .wdata_i (wr_data_i),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  // Next-state and registered-output values.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    bus_d    = '0;
    valid_d  = 1'b0;
    wr_err_d = wr_en_i && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        // After a HALT, run_i must be seen low before a restart.
        if (run_i && (!halted_q || !run_q)) begin
          addr_d   = '0;
          halted_d = 1'b0;
          state_d  = ST_OPCODE;
        end
      end
      ST_OPCODE: state_d = ST_IMM;
      ST_IMM: begin
        if (rd_data[WORD_W-1:BYTE_W] == HALT_OPCODE) begin
          halted_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_WAIT_REQ;
        end
      end
      ST_WAIT_REQ: begin
        if (req_edge) begin
          state_d = ST_ADDR;
          if (cpu_invalid_i && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ADDR: begin
        addr_d  = cpu_pc_i;
        state_d = ST_OPCODE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Host stop overrides everything outside IDLE; sticky status is held.
    if ((state_q != ST_IDLE) && !run_i) begin
      state_d  = ST_IDLE;
      addr_d   = addr_q;
      halted_d = halted_q;
      cnt_d    = cnt_q;
    end

    case (state_d)
      ST_OPCODE: begin
        bus_d   = fwd_data[WORD_W-1:BYTE_W];
        valid_d = 1'b1;
      end
      ST_IMM: begin
        bus_d   = fwd_data[BYTE_W-1:0];
        valid_d = 1'b1;
      end
      default: begin
        bus_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      req_q    <= 1'b0;
      run_q    <= 1'b0;
      bus_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      wr_err_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      req_q    <= cpu_req_i;
      run_q    <= run_i;
      bus_q    <= bus_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      wr_err_q <= wr_err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cpu_bus_o       = bus_q;
  assign cpu_bus_valid_o = valid_q;
  assign halted_o        = halted_q;
  assign wr_err_o        = wr_err_q;
  assign invalid_cnt_o   = cnt_q;

endmodule

// File: tb/tb_prog_feeder.sv
// Directed + randomized bench for prog_feeder with a word-array reference model.
module tb_prog_feeder;
  import prog_feeder_pkg::*;

  localparam int unsigned AW = 6;
  localparam int unsigned DP = 64;

  logic          clk;
  logic          rst;
  logic          run_i;
  logic          wr_en_i;
  logic [AW-1:0] wr_addr_i;
  logic [15:0]   wr_data_i;
  logic          cpu_req_i;
  logic          cpu_invalid_i;
  logic [AW-1:0] cpu_pc_i;
  logic [7:0]    cpu_bus_o;
  logic          cpu_bus_valid_o;
  logic          halted_o;
  logic          wr_err_o;
  logic [7:0]    invalid_cnt_o;

  prog_feeder #(.DEPTH(DP), .ADDR_W(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .run_i           (run_i),
    .wr_en_i         (wr_en_i),
    .wr_addr_i       (wr_addr_i),
    .wr_data_i       (wr_data_i),
    .cpu_req_i       (cpu_req_i),
    .cpu_invalid_i   (cpu_invalid_i),
    .cpu_pc_i        (cpu_pc_i),
    .cpu_bus_o       (cpu_bus_o),
    .cpu_bus_valid_o (cpu_bus_valid_o),
    .halted_o        (halted_o),
    .wr_err_o        (wr_err_o),
    .invalid_cnt_o   (invalid_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [15:0] model_mem [DP];
  int exp_cnt = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] bus_word();
    return {7'd0, cpu_bus_valid_o, cpu_bus_o};
  endfunction

  task automatic host_write(input logic [AW-1:0] a, input logic [15:0] d);
    wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
    model_mem[a] = d;
    step();
    wr_en_i = 1'b0;
    chk("wr_err_idle", 16'(wr_err_o), 16'd0);
  endtask

  // One request pulse from WAIT_REQ; checks both bytes and the aftermath.
  task automatic fetch(input logic [AW-1:0] pc, input logic inv);
    logic [15:0] w;
    w = model_mem[pc];
    cpu_req_i = 1'b1; cpu_pc_i = pc; cpu_invalid_i = inv;
    step();
    chk("addr_cycle_idle", bus_word(), 16'd0);
    cpu_req_i = 1'b0;
    if (inv && exp_cnt < 255) exp_cnt++;
    step();
    chk("fetch_opcode", bus_word(), {8'h01, w[15:8]});
    step();
    chk("fetch_imm", bus_word(), {8'h01, w[7:0]});
    step();
    chk("fetch_after", bus_word(), 16'd0);
    chk("fetch_halted", 16'(halted_o), 16'(w[15:8] == 8'hFF));
    chk("fetch_cnt", 16'(invalid_cnt_o), 16'(exp_cnt));
  endtask

  initial begin
    logic [15:0] d;
    int nvalid;
    rst = 1'b1; run_i = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    cpu_req_i = 1'b0; cpu_invalid_i = 1'b0; cpu_pc_i = '0;
    #12;
    chk("rst_bus", 16'(cpu_bus_o), 16'd0);
    chk("rst_valid", 16'(cpu_bus_valid_o), 16'd0);
    chk("rst_halted", 16'(halted_o), 16'd0);
    chk("rst_wr_err", 16'(wr_err_o), 16'd0);
    chk("rst_cnt", 16'(invalid_cnt_o), 16'd0);
    rst = 1'b0;
    step();

    // Random program without HALT opcodes, plus the fixed words.
    for (int i = 1; i < int'(DP); i++) begin
      d = 16'($urandom);
      if (d[15:8] == 8'hFF) d[15:8] = 8'h3C;
      host_write(AW'(i), d);
    end
    host_write(AW'(1), 16'hFF00);
    host_write(AW'(3), 16'hA7C3);

    // Write of word 0 coincides with run: first opcode must be the new word.
    wr_en_i = 1'b1; wr_addr_i = '0; wr_data_i = 16'h1205; run_i = 1'b1;
    model_mem[0] = 16'h1205;
    step();
    wr_en_i = 1'b0;
    chk("start_opcode", bus_word(), 16'h0112);
    step();
    chk("start_imm", bus_word(), 16'h0105);
    step();
    chk("start_after", bus_word(), 16'h0000);

    fetch(AW'(3), 1'b0);

    // Request held high: exactly one fetch (two valid bytes).
    nvalid = 0;
    cpu_pc_i = AW'(2); cpu_req_i = 1'b1;
    repeat (5) begin step(); if (cpu_bus_valid_o) nvalid++; end
    cpu_req_i = 1'b0;
    repeat (3) begin step(); if (cpu_bus_valid_o) nvalid++; end
    chk("hold_one_fetch", 16'(nvalid), 16'd2);

    repeat (10) fetch(AW'($urandom_range(2, 63)), 1'($urandom_range(0, 1)));

    repeat (300) fetch(AW'($urandom_range(2, 63)), 1'b1);
    chk("cnt_saturated", 16'(invalid_cnt_o), 16'd255);

    // Write attempted during IMM: rejected, pulse, memory unchanged.
    cpu_invalid_i = 1'b0;
    cpu_req_i = 1'b1; cpu_pc_i = AW'(3);
    step();
    cpu_req_i = 1'b0;
    step();
    step();
    chk("imm_before_wr", bus_word(), 16'h01C3);
    wr_en_i = 1'b1; wr_addr_i = AW'(3); wr_data_i = 16'h0000;
    step();
    wr_en_i = 1'b0;
    chk("wr_err_pulse", 16'(wr_err_o), 16'd1);
    step();
    chk("wr_err_clear", 16'(wr_err_o), 16'd0);
    fetch(AW'(3), 1'b0);

    // Stop mid-fetch: back to IDLE, status held, then restart at word 0.
    cpu_req_i = 1'b1; cpu_pc_i = AW'(5);
    step();
    cpu_req_i = 1'b0;
    step();
    run_i = 1'b0;
    step();
    chk("stop_bus", bus_word(), 16'd0);
    chk("stop_cnt", 16'(invalid_cnt_o), 16'd255);
    run_i = 1'b1;
    step();
    chk("restart_opcode", bus_word(), 16'h0112);
    step();
    step();

    // Reset during OPCODE: outputs clear at once, memory survives.
    cpu_req_i = 1'b1; cpu_pc_i = AW'(3);
    step();
    cpu_req_i = 1'b0;
    step();
    chk("pre_rst_opcode", bus_word(), 16'h01A7);
    rst = 1'b1;
    #1;
    chk("midrst_bus", bus_word(), 16'd0);
    chk("midrst_cnt", 16'(invalid_cnt_o), 16'd0);
    chk("midrst_halted", 16'(halted_o), 16'd0);
    exp_cnt = 0;
    #2;
    rst = 1'b0;
    step();
    chk("post_rst_opcode", bus_word(), 16'h0112);
    step();
    chk("post_rst_imm", bus_word(), 16'h0105);
    step();

    // HALT: served, then idle while run stays high, until run toggles.
    fetch(AW'(1), 1'b0);
    repeat (4) step();
    chk("halt_no_restart", bus_word(), 16'd0);
    chk("halt_sticky", 16'(halted_o), 16'd1);
    run_i = 1'b0;
    step();
    chk("halt_held_stop", 16'(halted_o), 16'd1);
    run_i = 1'b1;
    step();
    chk("halt_restart_opcode", bus_word(), 16'h0112);
    chk("halt_cleared", 16'(halted_o), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_feeder.md
PROG_FEEDER -- requirements
Module: prog_feeder

Interface
REQ-001 Parameter DEPTH, default 64, number of program words; SHALL equal 2**ADDR_W.
REQ-002 Parameter ADDR_W, default 6, program address width; SHALL match the CPU PC field width.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset; SHALL be asynchronous and active-high.
REQ-005 Port run_i  input  1  host start/stop; high = serve CPU, low = stop and return to IDLE.
REQ-006 Port wr_en_i  input  1  host program-write strobe.
REQ-007 Port wr_addr_i  input  ADDR_W  host write address.
REQ-008 Port wr_data_i  input  16  program word: [15:8] opcode, [7:0] immediate.
REQ-009 Port cpu_req_i  input  1  CPU next-instruction request (send_ins).
REQ-010 Port cpu_invalid_i  input  1  CPU invalid-instruction flag.
REQ-011 Port cpu_pc_i  input  ADDR_W  CPU program counter.
REQ-012 Port cpu_bus_o  output  8  byte driven onto the CPU instruction input.
REQ-013 Port cpu_bus_valid_o  output  1  cpu_bus_o holds an opcode or immediate this cycle.
REQ-014 Port halted_o  output  1  sticky: HALT opcode has been served.
REQ-015 Port wr_err_o  output  1  one-cycle pulse: host write rejected.
REQ-016 Port invalid_cnt_o  output  8  saturating count of invalid-instruction requests.

Function
REQ-017 States: IDLE, OPCODE, IMM, WAIT_REQ, ADDR; one state per cycle except IDLE and WAIT_REQ, which hold.
REQ-018 IDLE: cpu_bus_o=0, valid=0; run_i=1 SHALL set addr=0, clear halted_o, go to OPCODE.
REQ-019 OPCODE: cpu_bus_o=mem[addr][15:8], valid=1, exactly one cycle; next state IMM.
REQ-020 IMM: cpu_bus_o=mem[addr][7:0], valid=1, exactly one cycle; next state WAIT_REQ, or IDLE with halted_o=1 if the opcode served was HALT_OPCODE (8'hFF).
REQ-021 WAIT_REQ: cpu_bus_o=0, valid=0; a rising edge of cpu_req_i (edge detect on a registered copy) SHALL move to ADDR.
REQ-022 Level-high cpu_req_i without a rising edge SHALL NOT trigger a new fetch.
REQ-023 ADDR: latch cpu_pc_i into addr, valid=0; next state OPCODE. The latency from request edge to opcode valid SHALL be exactly 2 cycles.
REQ-024 invalid_cnt_o SHALL increment by 1 on each detected request edge with cpu_invalid_i=1, saturating at 255.
REQ-025 Host writes SHALL be accepted only in IDLE; memory updates at the edge where wr_en_i=1.
REQ-026 wr_en_i=1 outside IDLE SHALL leave memory unchanged and pulse wr_err_o high for exactly one cycle.
REQ-027 Simultaneous wr_en_i and run_i in IDLE: the write SHALL complete; the following OPCODE cycle SHALL read the new word.
REQ-028 run_i=0 in any non-IDLE state SHALL force IDLE at the next edge, with valid=0 from that cycle; halted_o and invalid_cnt_o SHALL be held.
REQ-029 All outputs SHALL be registered; cpu_bus_o SHALL be 0 whenever valid=0.

Reset
REQ-030 rst=1 SHALL immediately set: state=IDLE, addr=0, cpu_bus_o=0, cpu_bus_valid_o=0, halted_o=0, wr_err_o=0, invalid_cnt_o=0, request edge register=0.
REQ-031 Program memory contents SHALL NOT be cleared by reset. A reset mid-fetch SHALL abandon the fetch with no partial output.

Structure
REQ-032 Shared package SHALL hold: state encoding, HALT_OPCODE=8'hFF, DEPTH/ADDR_W defaults, counter saturation value.
REQ-033 Sub-module prog_mem SHALL hold the DEPTH x 16 register array, with synchronous write and asynchronous read; the FSM and counters SHALL reside in prog_feeder.

Verification
REQ-034 Write mem[0]=16'h1205, then run_i=1 -> OPCODE cycle bus=8'h12 valid=1, next cycle bus=8'h05 valid=1, then valid=0.
REQ-035 In WAIT_REQ, pulse cpu_req_i with cpu_pc_i=6'd3, mem[3]=16'hA7C3 -> two cycles later bus=8'hA7, then 8'hC3.
REQ-036 Hold cpu_req_i high 5 cycles -> exactly one fetch; pulse 300 times with cpu_invalid_i=1 -> invalid_cnt_o=255.
REQ-037 mem[1]=16'hFF00, request pc=1 -> bytes FF then 00 served, then IDLE, halted_o=1; run_i kept high -> no restart until run_i toggles low then high.
REQ-038 wr_en_i during IMM -> wr_err_o high for one cycle, memory readback unchanged; assert rst during OPCODE -> all outputs 0 in the same cycle, memory intact.
